// File: rtl/rx_uart.sv
// UART receiver: 2-flop synchronized RX line, oversampled mid-bit sampling, 8 data + parity + stop.
// Optional RX_MAJORITY_VOTE_EN: each bit is the majority of three samples around mid-bit.
module rx_uart #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_tick,
  input  logic       serial_in,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_framing_err,
  output logic       o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
`ifdef RX_MAJORITY_VOTE_EN
  localparam int START_LAST = OVERSAMPLE / 2;
`else
  localparam int START_LAST = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [CW-1:0] START_END = CW'(START_LAST);
  localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      o_data_q, o_data_d;
  logic            o_valid_q, o_valid_d;
  logic            o_parity_err_q, o_parity_err_d;
  logic            o_framing_err_q, o_framing_err_d;
  logic            o_busy_q, o_busy_d;
  logic [CW-1:0]   end_cnt;
  logic            at_end;
  logic            bit_s;

`ifdef RX_MAJORITY_VOTE_EN
  logic v0_q, v0_d, v1_q, v1_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      par_q           <= 1'b0;
      o_data_q        <= '0;
      o_valid_q       <= 1'b0;
      o_parity_err_q  <= 1'b0;
      o_framing_err_q <= 1'b0;
      o_busy_q        <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
      v0_q            <= 1'b1;
      v1_q            <= 1'b1;
`endif
    end else begin
      rx_meta_q       <= serial_in;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      par_q           <= par_d;
      o_data_q        <= o_data_d;
      o_valid_q       <= o_valid_d;
      o_parity_err_q  <= o_parity_err_d;
      o_framing_err_q <= o_framing_err_d;
      o_busy_q        <= o_busy_d;
`ifdef RX_MAJORITY_VOTE_EN
      v0_q            <= v0_d;
      v1_q            <= v1_d;
`endif
    end
  end

  // The decision tick is the last of the samples; with voting the two earlier ticks are latched.
  always_comb begin
    end_cnt = (state_q == START) ? START_END : BIT_END;
    at_end  = sample_tick && (cnt_q == end_cnt);
`ifdef RX_MAJORITY_VOTE_EN
    bit_s = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
    v0_d  = v0_q;
    v1_d  = v1_q;
    if (sample_tick && (cnt_q == end_cnt - CW'(2))) v0_d = rx_s_q;
    if (sample_tick && (cnt_q == end_cnt - CW'(1))) v1_d = rx_s_q;
`else
    bit_s = rx_s_q;
`endif
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    par_d           = par_q;
    o_data_d        = o_data_q;
    o_valid_d       = 1'b0;
    o_parity_err_d  = o_parity_err_q;
    o_framing_err_d = o_framing_err_q;
    if (sample_tick && !at_end) cnt_d = cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sample_tick && !rx_s_q) state_d = START;
      end
      START: if (at_end) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = bit_s ? IDLE : DATA;
      end
      DATA: if (at_end) begin
        cnt_d = '0;
        shift_d[idx_q] = bit_s;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (at_end) begin
        cnt_d   = '0;
        par_d   = bit_s;
        state_d = STOP;
      end
      STOP: if (at_end) begin
        cnt_d           = '0;
        o_data_d        = shift_q;
        o_parity_err_d  = par_q != ((^shift_q) ^ ODD);
        o_framing_err_d = !bit_s;
        o_valid_d       = 1'b1;
        state_d         = bit_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (sample_tick && rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy_d = (state_q != IDLE);
  end

  assign o_data        = o_data_q;
  assign o_valid       = o_valid_q;
  assign o_parity_err  = o_parity_err_q;
  assign o_framing_err = o_framing_err_q;
  assign o_busy        = o_busy_q;

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: OVERSAMPLE=16, tick every 4 clk, so one bit period is 64 clk.
module tb_rx_uart;
  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_framing_err, o_busy;

  int checks = 0;
  int errors = 0;

  int         vcnt = 0;
  longint     cyc = 0;
  longint     vcyc = 0;
  logic [7:0] cap_data = '0;
  logic       cap_par = 1'b0, cap_fr = 1'b0, cap_busy = 1'b0, busy_after = 1'b0;
  logic       prev_valid = 1'b0;

  rx_uart #(.OVERSAMPLE(16), .PARITY_ODD(0)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .serial_in(serial_in),
    .o_data(o_data), .o_valid(o_valid), .o_parity_err(o_parity_err),
    .o_framing_err(o_framing_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    int unsigned tdiv;
    tdiv = 0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      sample_tick = (tdiv == 0);
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_valid) busy_after = o_busy;
    if (o_valid) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
      cap_data = o_data;
      cap_par = o_parity_err;
      cap_fr = o_framing_err;
      cap_busy = o_busy;
    end
    prev_valid = o_valid;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  initial begin
    int     v0;
    longint c1;

    // reset state
    wait_clk(5);
    chk("rst_data", o_data, 8'h00);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_perr", o_parity_err, 1'b0);
    chk("rst_ferr", o_framing_err, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    reset_n = 1'b1;

    // idle 200 ticks
    wait_clk(800);
    chk("idle_vcnt", vcnt, 0);
    chk("idle_busy", o_busy, 1'b0);
    chk("idle_data", o_data, 8'h00);

    // good frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_vcnt", vcnt, 1);
    chk("a5_data", cap_data, 8'hA5);
    chk("a5_perr", cap_par, 1'b0);
    chk("a5_ferr", cap_fr, 1'b0);
    chk("a5_busy_at_valid", cap_busy, 1'b1);
    chk("a5_busy_after", busy_after, 1'b0);
    chk("a5_hold_data", o_data, 8'hA5);
    send_bit(1'b1);

    // wrong parity 0x3C
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("3c_vcnt", vcnt, 2);
    chk("3c_data", cap_data, 8'h3C);
    chk("3c_perr", cap_par, 1'b1);
    chk("3c_ferr", cap_fr, 1'b0);
    chk("3c_hold_perr", o_parity_err, 1'b1);
    send_bit(1'b1);

    // framing error, line stuck low
    send_frame(8'h55, 1'b0, 1'b0);
    chk("55_vcnt", vcnt, 3);
    chk("55_data", cap_data, 8'h55);
    chk("55_perr", cap_par, 1'b0);
    chk("55_ferr", cap_fr, 1'b1);
    chk("55_busy_after", busy_after, 1'b1);
    wait_clk(2 * BIT_CLK);
    chk("55_busy_stuck", o_busy, 1'b1);
    chk("55_no_new_frame", vcnt, 3);
    wait_clk(BIT_CLK);
    send_bit(1'b1);
    chk("55_busy_released", o_busy, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1);
    chk("0f_vcnt", vcnt, 4);
    chk("0f_data", cap_data, 8'h0F);
    chk("0f_perr", cap_par, 1'b0);
    chk("0f_ferr", cap_fr, 1'b0);
    send_bit(1'b1);

    // 4-tick low glitch
    serial_in = 1'b0;
    wait_clk(12);
    chk("glitch_busy_hi", o_busy, 1'b1);
    wait_clk(4);
    serial_in = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("glitch_busy_lo", o_busy, 1'b0);
    chk("glitch_vcnt", vcnt, 4);

`ifdef RX_MAJORITY_VOTE_EN
    // 0xFF with a 1-tick spike in bit 3
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    serial_in = 1'b1;
    wait_clk(30);
    serial_in = 1'b0;
    wait_clk(4);
    serial_in = 1'b1;
    wait_clk(BIT_CLK - 34);
    for (int i = 4; i < 8; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("ff_vcnt", vcnt, 5);
    chk("ff_data", cap_data, 8'hFF);
    chk("ff_perr", cap_par, 1'b0);
    send_bit(1'b1);
`endif

    // back-to-back 0x01 then 0x80
    v0 = vcnt;
    send_frame(8'h01, 1'b1, 1'b1);
    chk("b2b1_vcnt", vcnt, v0 + 1);
    chk("b2b1_data", cap_data, 8'h01);
    chk("b2b1_perr", cap_par, 1'b0);
    c1 = vcyc;
    send_frame(8'h80, 1'b1, 1'b1);
    chk("b2b2_vcnt", vcnt, v0 + 2);
    chk("b2b2_data", cap_data, 8'h80);
    chk("b2b2_perr", cap_par, 1'b0);
    chk("b2b_spacing", vcyc - c1, 11 * BIT_CLK);

    // reset during bit 4 of a third frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    wait_clk(32);
    serial_in = 1'b1;
    reset_n = 1'b0;
    wait_clk(2);
    chk("abort_data", o_data, 8'h00);
    chk("abort_valid", o_valid, 1'b0);
    chk("abort_perr", o_parity_err, 1'b0);
    chk("abort_ferr", o_framing_err, 1'b0);
    chk("abort_busy", o_busy, 1'b0);
    reset_n = 1'b1;
    wait_clk(8 * BIT_CLK);
    chk("abort_vcnt", vcnt, v0 + 2);
    chk("abort_busy_after", o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
